midi_preset_ctrl: RTL and testbench

MIDI_PRESET_CTRL -- requirements
Module: midi_preset_ctrl

---
 rtl/midi_preset_ctrl.sv | 154 +++++++++++++++
 tb/tb_midi_preset_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_preset_ctrl.sv
// ============================================================================
// Module   : midi_preset_ctrl
// Purpose  : Preset-button MIDI controller. Buttons send learned or default CC
//            messages; learn mode captures an incoming message into a slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_preset_ctrl #(
  parameter int BUTTONS  = 4,
  parameter int CHANNEL  = 0,
  parameter int FIRST_CC = 46,
  parameter int TOGGLE   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BUTTONS-1:0] btn_press,
  input  logic               learn,
  input  logic               rx_valid,
  input  logic [7:0]         rx_status,
  input  logic [7:0]         rx_data1,
  input  logic [7:0]         rx_data2,
  input  logic [1:0]         rx_len,
  output logic               tx_valid,
  output logic [7:0]         tx_status,
  output logic [7:0]         tx_data1,
  output logic [7:0]         tx_data2,
  output logic [1:0]         tx_len,
  input  logic               tx_ready,
  output logic [BUTTONS-1:0] learned,
  output logic               armed
);

  localparam int         IW           = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;
  localparam logic [7:0] c_def_status = 8'hB0 | 8'(CHANNEL & 15);
  localparam logic [6:0] c_first_cc   = 7'(FIRST_CC % 128);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]         r_tx_status, r_tx_data1, r_tx_data2;
  logic [1:0]         r_tx_len;
  logic [BUTTONS-1:0] r_learned;
  logic [BUTTONS-1:0] r_toggle;
  logic [IW-1:0]      r_target;
  logic [IW-1:0]      r_sel;

  // Slot contents are deliberately unreset; learned qualifies them.
  logic [7:0] r_slot_status [BUTTONS];
  logic [7:0] r_slot_data1  [BUTTONS];
  logic [7:0] r_slot_data2  [BUTTONS];
  logic [1:0] r_slot_len    [BUTTONS];

  logic          w_btn_any;
  logic [IW-1:0] w_btn_idx;
  logic          w_store;
  logic [IW-1:0] w_store_idx;
  logic [7:0]    w_def_data1;
  logic [7:0]    w_def_data2;

  // Lowest pressed index wins; scanning downward leaves it as the final value.
  always_comb begin
    w_btn_idx = '0;
    for (int i = BUTTONS - 1; i >= 0; i--) begin
      if (btn_press[i]) w_btn_idx = IW'(i);
    end
  end

  assign w_btn_any   = |btn_press;
  assign w_store     = (r_state == ARM) && learn && rx_valid && (rx_len != 2'd0);
  assign w_store_idx = w_btn_any ? w_btn_idx : r_target;
  assign w_def_data1 = {1'b0, c_first_cc + 7'(w_btn_idx)};
  assign w_def_data2 = ((TOGGLE != 0) && r_toggle[w_btn_idx]) ? 8'd0 : 8'd127;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_btn_any) w_next = learn ? ARM : SEND;
      ARM: begin
        if (!learn)       w_next = IDLE;
        else if (w_store) w_next = IDLE;
      end
      SEND:    if (tx_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_status <= '0;
      r_tx_data1  <= '0;
      r_tx_data2  <= '0;
      r_tx_len    <= '0;
      r_learned   <= '0;
      r_toggle    <= '0;
      r_target    <= '0;
      r_sel       <= '0;
    end else begin
      if ((r_state == IDLE) && !learn && w_btn_any) begin
        r_sel <= w_btn_idx;
        if (r_learned[w_btn_idx]) begin
          r_tx_status <= r_slot_status[w_btn_idx];
          r_tx_data1  <= r_slot_data1[w_btn_idx];
          r_tx_data2  <= r_slot_data2[w_btn_idx];
          r_tx_len    <= r_slot_len[w_btn_idx];
        end else begin
          r_tx_status <= c_def_status;
          r_tx_data1  <= w_def_data1;
          r_tx_data2  <= w_def_data2;
          r_tx_len    <= 2'd3;
        end
      end
      if (((r_state == IDLE) || (r_state == ARM)) && learn && w_btn_any)
        r_target <= w_btn_idx;
      if (w_store) begin
        r_learned[w_store_idx] <= 1'b1;
        r_toggle[w_store_idx]  <= 1'b0;
      end
      if ((r_state == SEND) && tx_ready && (TOGGLE != 0))
        r_toggle[r_sel] <= ~r_toggle[r_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_slot_status[w_store_idx] <= rx_status;
      r_slot_data1[w_store_idx]  <= rx_data1;
      r_slot_data2[w_store_idx]  <= rx_data2;
      r_slot_len[w_store_idx]    <= rx_len;
    end
  end

  assign armed     = (r_state == ARM);
  assign tx_valid  = (r_state == SEND);
  assign tx_status = r_tx_status;
  assign tx_data1  = r_tx_data1;
  assign tx_data2  = r_tx_data2;
  assign tx_len    = r_tx_len;
  assign learned   = r_learned;

endmodule

`default_nettype wire

// File: tb/tb_midi_preset_ctrl.sv
// ============================================================================
// Module   : tb_midi_preset_ctrl
// Purpose  : Scoreboard bench for midi_preset_ctrl (default and 16-button).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_preset_ctrl;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } msg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = '0;
  logic        learn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_status = '0, rx_data1 = '0, rx_data2 = '0;
  logic [1:0]  rx_len = '0;
  logic        tx_ready = 1'b1;
  logic        tx_valid, armed;
  logic [7:0]  tx_status, tx_data1, tx_data2;
  logic [1:0]  tx_len;
  logic [3:0]  learned;

  logic        rst_b = 1'b1;
  logic [15:0] btn_b = '0;
  logic        learn_b = 1'b0;
  logic        rx_valid_b = 1'b0;
  logic        tx_ready_b = 1'b1;
  logic        tx_valid_b, armed_b;
  logic [7:0]  tx_status_b, tx_data1_b, tx_data2_b;
  logic [1:0]  tx_len_b;
  logic [15:0] learned_b;

  int   total = 0;
  int   bad = 0;
  msg_t exp_q[$];
  msg_t e;
  msg_t g;

  always #5 clk = ~clk;

  midi_preset_ctrl dut (
    .clk(clk), .rst(rst), .btn_press(btn), .learn(learn),
    .rx_valid(rx_valid), .rx_status(rx_status), .rx_data1(rx_data1),
    .rx_data2(rx_data2), .rx_len(rx_len),
    .tx_valid(tx_valid), .tx_status(tx_status), .tx_data1(tx_data1),
    .tx_data2(tx_data2), .tx_len(tx_len), .tx_ready(tx_ready),
    .learned(learned), .armed(armed)
  );

  midi_preset_ctrl #(.BUTTONS(16), .FIRST_CC(120)) dut_b (
    .clk(clk), .rst(rst_b), .btn_press(btn_b), .learn(learn_b),
    .rx_valid(rx_valid_b), .rx_status(rx_status), .rx_data1(rx_data1),
    .rx_data2(rx_data2), .rx_len(rx_len),
    .tx_valid(tx_valid_b), .tx_status(tx_status_b), .tx_data1(tx_data1_b),
    .tx_data2(tx_data2_b), .tx_len(tx_len_b), .tx_ready(tx_ready_b),
    .learned(learned_b), .armed(armed_b)
  );

  function automatic msg_t pop_exp();
    msg_t m;
    m = 'x;
    if (exp_q.size() != 0) m = exp_q.pop_front();
    return m;
  endfunction

  // Inputs change on the falling edge; outputs are read there too.
  task automatic press(input int i);
    btn[i] = 1'b1;
    @(negedge clk);
    btn = '0;
  endtask

  task automatic press_b(input int i);
    btn_b[i] = 1'b1;
    @(negedge clk);
    btn_b = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({tx_valid, armed, learned} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 000000", {tx_valid, armed, learned});
    end
    total++;
    if ({tx_status, tx_data1, tx_data2, tx_len} !== 26'b0) begin
      bad++;
      $display("FAIL reset_tx: got %h expected 0", {tx_status, tx_data1, tx_data2, tx_len});
    end
    rst = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_toggle();
    learn = 1'b0;
    tx_ready = 1'b1;
    exp_q.push_back('{8'hB0, 8'h2F, 8'h7F, 2'd3});
    exp_q.push_back('{8'hB0, 8'h2F, 8'h00, 2'd3});
    for (int k = 0; k < 2; k++) begin
      press(1);
      g = {tx_status, tx_data1, tx_data2, tx_len};
      e = pop_exp();
      total++;
      if (!tx_valid || g !== e) begin
        bad++;
        $display("FAIL default_msg%0d: got v=%b %h expected v=1 %h", k, tx_valid, g, e);
      end
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b0) begin
        bad++;
        $display("FAIL default_idle%0d: got tx_valid=%b expected 0", k, tx_valid);
      end
    end
  endtask

  task automatic test_learn();
    learn = 1'b1;
    press(2);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("FAIL learn_armed: got %b expected 1", armed);
    end
    rx_status = 8'hC0; rx_data1 = 8'h42; rx_data2 = 8'h00; rx_len = 2'd2;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if ({armed, learned} !== 5'b0_0100) begin
      bad++;
      $display("FAIL learn_store: got armed=%b learned=%b expected armed=0 learned=0100", armed, learned);
    end
    learn = 1'b0;
    exp_q.push_back('{8'hC0, 8'h42, 8'h00, 2'd2});
    press(2);
    g = {tx_status, tx_data1, tx_data2, tx_len};
    e = pop_exp();
    total++;
    if (!tx_valid || g !== e) begin
      bad++;
      $display("FAIL learned_send: got v=%b %h expected v=1 %h", tx_valid, g, e);
    end
    @(negedge clk);
  endtask

  task automatic test_multi_press();
    exp_q.push_back('{8'hB0, 8'h2E, 8'h7F, 2'd3});
    btn = 4'b1001;
    @(negedge clk);
    btn = '0;
    g = {tx_status, tx_data1, tx_data2, tx_len};
    e = pop_exp();
    total++;
    if (!tx_valid || g !== e) begin
      bad++;
      $display("FAIL multi_press: got v=%b %h expected v=1 %h", tx_valid, g, e);
    end
    total++;
    if (learned !== 4'b0100) begin
      bad++;
      $display("FAIL multi_learned: got %b expected 0100", learned);
    end
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL multi_dropped: got tx_valid=%b expected 0", tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    exp_q.push_back('{8'hB0, 8'h2F, 8'h7F, 2'd3});
    press(1);
    for (int k = 0; k < 5; k++) begin
      btn = 4'($urandom_range(1, 15));
      rx_valid = 1'b1;
      @(negedge clk);
      g = {tx_status, tx_data1, tx_data2, tx_len};
      total++;
      if (!tx_valid || exp_q.size() != 1 || g !== exp_q[0]) begin
        bad++;
        $display("FAIL hold_stable%0d: got v=%b %h expected v=1 %h", k, tx_valid, g, exp_q[0]);
      end
    end
    btn = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    e = pop_exp();
    total++;
    if (!tx_valid || g !== e) begin
      bad++;
      $display("FAIL hold_release: got v=%b %h expected v=1 %h", tx_valid, g, e);
    end
    @(negedge clk);
    total++;
    if ({tx_valid, armed} !== 2'b00) begin
      bad++;
      $display("FAIL hold_idle: got %b expected 00", {tx_valid, armed});
    end
  endtask

  task automatic test_abort();
    learn = 1'b1;
    press(1);
    learn = 1'b0;
    rx_status = 8'h90; rx_data1 = 8'h3C; rx_data2 = 8'h40; rx_len = 2'd3;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if ({tx_valid, armed, learned} !== 6'b00_0100) begin
      bad++;
      $display("FAIL abort: got %b expected 000100", {tx_valid, armed, learned});
    end
    learn = 1'b1;
    press(3);
    rx_len = 2'd0;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if ({armed, learned} !== 5'b1_0100) begin
      bad++;
      $display("FAIL len0_ignored: got %b expected 10100", {armed, learned});
    end
    btn = 4'b0001;
    rx_status = 8'hB5; rx_data1 = 8'h11; rx_data2 = 8'h22; rx_len = 2'd3;
    rx_valid = 1'b1;
    @(negedge clk);
    btn = '0;
    rx_valid = 1'b0;
    total++;
    if ({armed, learned} !== 5'b0_0101) begin
      bad++;
      $display("FAIL retarget_store: got %b expected 00101", {armed, learned});
    end
    learn = 1'b0;
    exp_q.push_back('{8'hB5, 8'h11, 8'h22, 2'd3});
    press(0);
    g = {tx_status, tx_data1, tx_data2, tx_len};
    e = pop_exp();
    total++;
    if (!tx_valid || g !== e) begin
      bad++;
      $display("FAIL retarget_send: got v=%b %h expected v=1 %h", tx_valid, g, e);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_reset();
    learn_b = 1'b1;
    press_b(5);
    rx_status = 8'hC0; rx_data1 = 8'h42; rx_data2 = 8'h00; rx_len = 2'd2;
    rx_valid_b = 1'b1;
    @(negedge clk);
    rx_valid_b = 1'b0;
    learn_b = 1'b0;
    total++;
    if (learned_b !== 16'h0020) begin
      bad++;
      $display("FAIL wrap_learned: got %h expected 0020", learned_b);
    end
    tx_ready_b = 1'b0;
    exp_q.push_back('{8'hB0, 8'h02, 8'h7F, 2'd3});
    press_b(10);
    g = {tx_status_b, tx_data1_b, tx_data2_b, tx_len_b};
    total++;
    if (!tx_valid_b || exp_q.size() != 1 || g !== exp_q[0]) begin
      bad++;
      $display("FAIL wrap_msg: got v=%b %h expected v=1 %h", tx_valid_b, g, exp_q[0]);
    end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    void'(pop_exp());
    total++;
    if ({tx_valid_b, armed_b, learned_b} !== 18'b0) begin
      bad++;
      $display("FAIL midsend_reset: got v=%b a=%b learned=%h expected 0 0 0000", tx_valid_b, armed_b, learned_b);
    end
    tx_ready_b = 1'b1;
    exp_q.push_back('{8'hB0, 8'h02, 8'h7F, 2'd3});
    press_b(10);
    g = {tx_status_b, tx_data1_b, tx_data2_b, tx_len_b};
    e = pop_exp();
    total++;
    if (!tx_valid_b || g !== e) begin
      bad++;
      $display("FAIL no_toggle_on_reset: got v=%b %h expected v=1 %h", tx_valid_b, g, e);
    end
    @(negedge clk);
    total++;
    if (tx_valid_b !== 1'b0) begin
      bad++;
      $display("FAIL wrap_idle: got %b expected 0", tx_valid_b);
    end
  endtask

  initial begin
    test_reset();
    test_default_toggle();
    test_learn();
    test_multi_press();
    test_back_to_back();
    test_abort();
    test_wrap_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
